apb_gpio: RTL and testbench
===========================

Name: apb_gpio

Overview:
- APB3/APB4 slave that terminates the downstream side of the APB delayer stage in the SoC peripheral fabric; connects to the delayer's out_* bus.
- Exposes board I/O as memory-mapped registers: 16 LEDs, 16 switches, and an 8-digit 7-segment display.
- Inserts a programmable number of wait states, so the delay path upstream is exercised against a slave that does not respond in zero wait states.

Parameters:
- WAIT_CYCLES, 1: pready wait states inserted in the ACCESS phase. Legal range 0..15.
- ADDR_MASK, 32'h0000_0FFF: mask applied to in_paddr to form the register offset.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_paddr  in  32  APB address
- in_psel  in  1  APB select
- in_penable  in  1  APB enable
- in_pprot  in  3  APB protection; ignored
- in_pwrite  in  1  1 = write
- in_pwdata  in  32  write data
- in_pstrb  in  4  byte write strobes
- in_pready  out  1  transfer complete
- in_prdata  out  32  read data
- in_pslverr  out  1  error response
- gpio_out  out  16  LED drive
- gpio_in  in  16  switch inputs; asynchronous to clock
- seg0..seg7  out  8 each  digit segment drive, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset values: in_pready=0, in_prdata=0, in_pslverr=0, gpio_out=0, SEG=0, SEG_EN=0, all seg* = 8'hFF, synchronizer flops = 0, FSM = IDLE.
- Register map (off = in_paddr & ADDR_MASK):
  - 0x0 LED: RW, bits[15:0]; bits[31:16] read as 0.
  - 0x4 SW: RO; returns the synchronized gpio_in in bits[15:0].
  - 0x8 SEG: RW, 32 bits; 8 hex nibbles, nibble i drives digit i.
  - 0xC SEG_EN: RW, bits[7:0]; bit i enables digit i.
- Error cases, both returning in_pslverr=1 with in_prdata=0 and no state change:
  - off >= 0x10, or off[1:0] != 0.
  - Any write to 0x4.
- gpio_in passes through a 2-flop synchronizer. A SW read returns the second-stage value.
- FSM states:
  - IDLE -> WAIT on psel & !penable (SETUP phase); load cnt = WAIT_CYCLES.
  - WAIT: while psel & penable & cnt != 0, decrement cnt. When cnt == 0, go to RESP.
  - RESP: assert in_pready for exactly one cycle. Read data and pslverr are valid in this same cycle. A write commits at the clock edge ending this cycle. Then go to IDLE.
- Latency from SETUP to pready:
  - WAIT_CYCLES=0: pready is high in the first ACCESS cycle (APB minimum of 2 cycles total).
  - Otherwise: pready is high in ACCESS cycle WAIT_CYCLES+1.
- Outside RESP: in_prdata=0 and in_pslverr=0.
- Writes honour in_pstrb per byte. Strobe bytes beyond a register's width are ignored. in_pstrb=0 completes normally with no change.
- A back-to-back SETUP in the cycle after RESP must be accepted; there is no dead cycle.
- If psel drops in WAIT (protocol violation): return to IDLE, no write, pready stays 0.
- seg decode: if SEG_EN[i]=0, segi = 8'hFF. Otherwise segi is the active-low hex glyph of SEG[4i+3:4i] with dp off. Examples: 0 -> 8'hC0, 8 -> 8'h80, F -> 8'h8E. Outputs are registered, one cycle after the SEG/SEG_EN update.
- Async reset mid-transfer: all outputs return to reset values immediately. A pending write is dropped.

Test Plan:
- Reset asserted mid-WAIT of a write of 0xBEEF to 0x0 -> in_pready drops that cycle; gpio_out stays 0x0000 after reset release.
- WAIT_CYCLES=1: write 0x0000_A5A5 to 0x0 with pstrb=4'b0001 -> pready in ACCESS cycle 2, pslverr=0, gpio_out=0x00A5. Follow with a read of 0x0 -> prdata=0x0000_00A5.
- gpio_in=0x1234 held ≥3 cycles; read 0x4 -> prdata=0x0000_1234. Then write 0x4 -> pslverr=1 and the register is unchanged.
- Write SEG=0x0123_456F, SEG_EN=0x81 -> seg0=8'h8E, seg7=8'hC0, seg1..seg6=8'hFF.
- Read 0x10 and read 0x6 -> each returns pslverr=1, prdata=0. A following read of 0x8 succeeds with pslverr=0.
- WAIT_CYCLES=0: back-to-back write then read to 0xC -> each transfer takes 2 cycles, and the read returns the written byte.

Source files
------------

// File: rtl/apb_gpio.sv
// apb_gpio: APB3/APB4 slave exposing board I/O as memory-mapped registers,
// with a programmable number of ACCESS-phase wait states.
//   clock, reset          : system clock, asynchronous active-high reset
//   in_p*                 : APB slave interface (in_pprot ignored)
//   gpio_out[15:0]        : LED drive (LED register)
//   gpio_in[15:0]         : switch inputs, asynchronous, 2-flop synchronized
//   seg0..seg7[7:0]       : active-low {dp,g,f,e,d,c,b,a} per digit, registered
// Register map (off = in_paddr & ADDR_MASK):
//   0x0 LED RW [15:0] | 0x4 SW RO [15:0] | 0x8 SEG RW [31:0] | 0xC SEG_EN RW [7:0]
module apb_gpio #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_MASK   = 32'h0000_0FFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [15:0] gpio_out,
  input  logic [15:0] gpio_in,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_pready;
  logic            r_pslverr;
  logic [31:0]     r_prdata;
  logic [15:0]     r_led;
  logic [31:0]     r_seg_val;
  logic [7:0]      r_seg_en;
  logic [15:0]     r_sync1;
  logic [15:0]     r_sync2;
  logic [7:0][7:0] r_seg;

  logic [31:0]     w_off;
  logic            w_err;
  logic [31:0]     w_rdata;
  logic [31:0]     w_resp_rdata;
  logic            w_unused;

  assign w_unused = ^in_pprot;

  assign w_off = in_paddr & ADDR_MASK;
  assign w_err = (w_off >= 32'h10) || (w_off[1:0] != 2'b00) ||
                 (in_pwrite && (w_off[3:2] == 2'd1));

  always_comb begin
    w_rdata = '0;
    case (w_off[3:2])
      2'd0: w_rdata = {16'h0000, r_led};
      2'd1: w_rdata = {16'h0000, r_sync2};
      2'd2: w_rdata = r_seg_val;
      2'd3: w_rdata = {24'h000000, r_seg_en};
      default: w_rdata = '0;
    endcase
  end

  // Response is captured on the edge entering RESP, so it is valid while pready is high.
  assign w_resp_rdata = (w_err || in_pwrite) ? '0 : w_rdata;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_led     <= '0;
      r_seg_val <= '0;
      r_seg_en  <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_seg     <= '1;
    end else begin
      r_sync1   <= gpio_in;
      r_sync2   <= r_sync1;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;

      for (int unsigned i = 0; i < 8; i++)
        r_seg[i] <= r_seg_en[i] ? glyph(r_seg_val[4*i +: 4]) : 8'hFF;

      case (r_state)
        S_IDLE: begin
          if (in_psel && !in_penable) begin
            r_cnt <= LP_WAIT;
            // Zero wait states: respond in the first ACCESS cycle, skipping WAIT.
            if (LP_WAIT == 4'd0) begin
              r_state   <= S_RESP;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_resp_rdata;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!in_psel) begin
            r_state <= S_IDLE;
          end else if (in_penable) begin
            // Last counted wait cycle: move to RESP so pready lands in ACCESS cycle N+1.
            if (r_cnt == 4'd1) begin
              r_state   <= S_RESP;
              r_cnt     <= '0;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_resp_rdata;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (in_psel && in_penable && in_pwrite && !r_pslverr) begin
            case (w_off[3:2])
              2'd0: begin
                for (int unsigned b = 0; b < 2; b++)
                  if (in_pstrb[b]) r_led[8*b +: 8] <= in_pwdata[8*b +: 8];
              end
              2'd2: begin
                for (int unsigned b = 0; b < 4; b++)
                  if (in_pstrb[b]) r_seg_val[8*b +: 8] <= in_pwdata[8*b +: 8];
              end
              2'd3: begin
                if (in_pstrb[0]) r_seg_en <= in_pwdata[7:0];
              end
              default: ;
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_pready  = r_pready;
  assign in_prdata  = r_prdata;
  assign in_pslverr = r_pslverr;
  assign gpio_out   = r_led;
  assign seg0 = r_seg[0];
  assign seg1 = r_seg[1];
  assign seg2 = r_seg[2];
  assign seg3 = r_seg[3];
  assign seg4 = r_seg[4];
  assign seg5 = r_seg[5];
  assign seg6 = r_seg[6];
  assign seg7 = r_seg[7];

endmodule

// File: tb/tb_apb_gpio.sv
// Bench for apb_gpio: one instance with one wait state, one with none.
module tb_apb_gpio;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] paddr, pwdata;
  logic        psel1, psel0, penable, pwrite;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic [15:0] gpio_in;

  logic        pready1, pslverr1, pready0, pslverr0;
  logic [31:0] prdata1, prdata0;
  logic [15:0] gpio_out1, gpio_out0;
  logic [7:0]  s1 [8];
  logic [7:0]  s0 [8];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  apb_gpio #(.WAIT_CYCLES(1), .ADDR_MASK(32'h0000_0FFF)) dut1 (
    .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel1),
    .in_penable(penable), .in_pprot(pprot), .in_pwrite(pwrite),
    .in_pwdata(pwdata), .in_pstrb(pstrb), .in_pready(pready1),
    .in_prdata(prdata1), .in_pslverr(pslverr1), .gpio_out(gpio_out1),
    .gpio_in(gpio_in),
    .seg0(s1[0]), .seg1(s1[1]), .seg2(s1[2]), .seg3(s1[3]),
    .seg4(s1[4]), .seg5(s1[5]), .seg6(s1[6]), .seg7(s1[7])
  );

  apb_gpio #(.WAIT_CYCLES(0), .ADDR_MASK(32'h0000_0FFF)) dut0 (
    .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel0),
    .in_penable(penable), .in_pprot(pprot), .in_pwrite(pwrite),
    .in_pwdata(pwdata), .in_pstrb(pstrb), .in_pready(pready0),
    .in_prdata(prdata0), .in_pslverr(pslverr0), .gpio_out(gpio_out0),
    .gpio_in(gpio_in),
    .seg0(s0[0]), .seg1(s0[1]), .seg2(s0[2]), .seg3(s0[3]),
    .seg4(s0[4]), .seg5(s0[5]), .seg6(s0[6]), .seg7(s0[7])
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  // Scoreboard monitors: pop one expected response per pready pulse.
  always @(negedge clock) begin
    if (pready1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected pready", 32'd1, 32'd0);
      end else begin
        check("dut1 prdata", prdata1, q1[0].rdata);
        check("dut1 pslverr", {31'b0, pslverr1}, {31'b0, q1[0].err});
        void'(q1.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (pready0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected pready", 32'd1, 32'd0);
      end else begin
        check("dut0 prdata", prdata0, q0[0].rdata);
        check("dut0 pslverr", {31'b0, pslverr0}, {31'b0, q0[0].err});
        void'(q0.pop_front());
      end
    end
  end

  function automatic logic rdy(input int d);
    return (d == 1) ? pready1 : pready0;
  endfunction

  // Returns at the negedge of the pready cycle; the next call starts SETUP right after.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    int   n;
    e.rdata = er;
    e.err   = ee;
    if (d == 1) q1.push_back(e); else q0.push_back(e);
    @(posedge clock); #1;
    psel1 = (d == 1); psel0 = (d == 0); penable = 1'b0;
    paddr = a; pwrite = w; pwdata = wd; pstrb = st;
    @(posedge clock); #1;
    penable = 1'b1;
    n = 1;
    @(negedge clock);
    while (!rdy(d) && n < 20) begin
      @(posedge clock); #1;
      n++;
      @(negedge clock);
    end
    check((d == 1) ? "dut1 latency" : "dut0 latency", n, lat);
  endtask

  task automatic idle();
    @(posedge clock); #1;
    psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; paddr = '0; pwdata = '0; psel1 = 1'b0; psel0 = 1'b0;
    penable = 1'b0; pwrite = 1'b0; pprot = '0; pstrb = '0; gpio_in = '0;
    repeat (2) @(negedge clock);
    check("reset pready", {31'b0, pready1}, 32'd0);
    check("reset prdata", prdata1, 32'd0);
    check("reset pslverr", {31'b0, pslverr1}, 32'd0);
    check("reset gpio_out", {16'b0, gpio_out1}, 32'd0);
    check("reset seg0", {24'b0, s1[0]}, 32'hFF);
    check("reset seg7", {24'b0, s1[7]}, 32'hFF);
    @(posedge clock); #1 reset = 1'b0;

    // Partial strobe write to LED, then read back.
    xfer(1, 32'h0, 1'b1, 32'h0000_A5A5, 4'b0001, 32'h0, 1'b0, 2);
    idle();
    check("led strobe", {16'b0, gpio_out1}, 32'h0000_00A5);
    xfer(1, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0000_00A5, 1'b0, 2);
    // Zero strobe: completes, no change.
    xfer(1, 32'h0, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 2);
    idle();
    check("led pstrb0", {16'b0, gpio_out1}, 32'h0000_00A5);

    // Switch read through synchronizer, then illegal write to SW.
    gpio_in = 16'h1234;
    repeat (3) @(posedge clock);
    xfer(1, 32'h4, 1'b0, 32'h0, 4'b0000, 32'h0000_1234, 1'b0, 2);
    xfer(1, 32'h4, 1'b1, 32'h0000_FFFF, 4'b1111, 32'h0, 1'b1, 2);
    xfer(1, 32'h4, 1'b0, 32'h0, 4'b0000, 32'h0000_1234, 1'b0, 2);
    idle();

    // Seven-segment decode.
    xfer(1, 32'h8, 1'b1, 32'h0123_456F, 4'b1111, 32'h0, 1'b0, 2);
    xfer(1, 32'hC, 1'b1, 32'h0000_0081, 4'b0001, 32'h0, 1'b0, 2);
    idle();
    repeat (2) @(negedge clock);
    check("seg0 F", {24'b0, s1[0]}, 32'h8E);
    check("seg7 0", {24'b0, s1[7]}, 32'hC0);
    for (int i = 1; i < 7; i++) check("seg blank", {24'b0, s1[i]}, 32'hFF);

    // Address errors, then a good read.
    xfer(1, 32'h10, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 2);
    xfer(1, 32'h6, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 2);
    xfer(1, 32'h8, 1'b0, 32'h0, 4'b0000, 32'h0123_456F, 1'b0, 2);
    // Upper LED bytes ignored; mask drops high address bits.
    xfer(1, 32'h8000_1000, 1'b1, 32'hFFFF_1234, 4'b1111, 32'h0, 1'b0, 2);
    xfer(1, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0000_1234, 1'b0, 2);
    idle();
    check("led upper ignored", {16'b0, gpio_out1}, 32'h0000_1234);

    // psel drops in WAIT: transfer abandoned.
    @(posedge clock); #1;
    psel1 = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'h5555; pstrb = 4'b1111;
    @(posedge clock); #1;
    psel1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort no pready", {31'b0, pready1}, 32'd0);
    end
    check("abort no write", {16'b0, gpio_out1}, 32'h0000_1234);

    // Async reset in WAIT of a write.
    @(posedge clock); #1;
    psel1 = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hBEEF; pstrb = 4'b0011;
    @(posedge clock); #1;
    penable = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("reset mid pready", {31'b0, pready1}, 32'd0);
    check("reset mid gpio", {16'b0, gpio_out1}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    idle();
    repeat (2) @(negedge clock);
    check("after reset gpio", {16'b0, gpio_out1}, 32'd0);
    check("after reset seg0", {24'b0, s1[0]}, 32'hFF);

    // Zero wait states, back-to-back.
    xfer(0, 32'hC, 1'b1, 32'h0000_005A, 4'b0001, 32'h0, 1'b0, 1);
    xfer(0, 32'hC, 1'b0, 32'h0, 4'b0000, 32'h0000_005A, 1'b0, 1);
    xfer(0, 32'hC, 1'b1, 32'hA5A5_A500, 4'b1110, 32'h0, 1'b0, 1);
    xfer(0, 32'hC, 1'b0, 32'h0, 4'b0000, 32'h0000_005A, 1'b0, 1);
    idle();
    repeat (2) @(negedge clock);
    check("dut0 seg1 on", {24'b0, s0[1]}, 32'hC0);
    check("dut0 seg0 off", {24'b0, s0[0]}, 32'hFF);

    repeat (2) @(negedge clock);
    check("dut1 queue drained", q1.size(), 32'd0);
    check("dut0 queue drained", q0.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
